// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle (8-bit address by default, 32-bit data) used between
// the command master and the register slave it drives.
interface axil_cmd_master_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: turns a {write, addr, wdata} command
// stream into one bus transaction and returns {rdata, resp, write, timeout}.
module axil_cmd_master #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_write,
  output logic              rsp_timeout,
  axil_cmd_master_if.master m
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TMO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_LAST_INT[CNT_W-1:0];
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              write_q;
  logic              aw_done, w_done;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              expire;
  logic              accept, aw_hs, w_hs, capture_b, capture_r, abort, in_bus;

  assign m.awaddr  = addr_q;
  assign m.araddr  = addr_q;
  assign m.wdata   = wdata_q;
  assign rsp_write = write_q;
  assign expire    = TMO_EN && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A completing handshake in the expiry cycle takes priority over the abort.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    m.awvalid  = 1'b0;
    m.wvalid   = 1'b0;
    m.bready   = 1'b0;
    m.arvalid  = 1'b0;
    m.rready   = 1'b0;
    accept     = 1'b0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    capture_b  = 1'b0;
    capture_r  = 1'b0;
    abort      = 1'b0;
    in_bus     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        in_bus    = 1'b1;
        m.awvalid = ~aw_done;
        m.wvalid  = ~w_done;
        aw_hs     = m.awvalid & m.awready;
        w_hs      = m.wvalid & m.wready;
        if ((aw_done | aw_hs) && (w_done | w_hs)) state_next = WR_RESP;
        else if (expire) begin
          abort      = 1'b1;
          state_next = RSP;
        end
      end
      WR_RESP: begin
        in_bus   = 1'b1;
        m.bready = 1'b1;
        if (m.bvalid) begin
          capture_b  = 1'b1;
          state_next = RSP;
        end else if (expire) begin
          abort      = 1'b1;
          state_next = RSP;
        end
      end
      RD_REQ: begin
        in_bus    = 1'b1;
        m.arvalid = 1'b1;
        if (m.arready) state_next = RD_RESP;
        else if (expire) begin
          abort      = 1'b1;
          state_next = RSP;
        end
      end
      RD_RESP: begin
        in_bus   = 1'b1;
        m.rready = 1'b1;
        if (m.rvalid) begin
          capture_r  = 1'b1;
          state_next = RSP;
        end else if (expire) begin
          abort      = 1'b1;
          state_next = RSP;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The timeout budget spans the whole transaction, not each phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      tmo_cnt     <= '0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        write_q <= cmd_write;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        tmo_cnt <= '0;
      end else if (in_bus && (tmo_cnt != TMO_LAST)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (capture_b) begin
        rsp_rdata   <= '0;
        rsp_resp    <= m.bresp;
        rsp_timeout <= 1'b0;
      end else if (capture_r) begin
        rsp_rdata   <= m.rdata;
        rsp_resp    <= m.rresp;
        rsp_timeout <= 1'b0;
      end else if (abort) begin
        rsp_rdata   <= '0;
        rsp_resp    <= 2'b10;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
